// File: rtl/display_scan_ctrl.sv
// Refresh scheduler for a 4-digit multiplexed 7-segment display: per-digit slots
// with anti-ghost blanking, and a double-buffered value that swaps only on frame
// boundaries. Define DISPLAY_LZB_EN to enable leading-zero blanking.
module display_scan_ctrl #(
  parameter int SLOT_CYCLES  = 8,
  parameter int BLANK_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        upd_valid,
  input  logic [15:0] upd_data,
  input  logic [3:0]  upd_dp,
  output logic        upd_ready,
  output logic [7:0]  segmentos,
  output logic [3:0]  sel_seg,
  output logic        frame_tick
);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_e;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  // With no blank phase every slot opens directly in SHOW.
  localparam state_e SLOT_START = (BLANK_CYCLES == 0) ? SHOW : BLANK;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic             boundary;

  logic [15:0]      act_data_q, pend_data_q;
  logic [3:0]       act_dp_q, pend_dp_q;
  logic             pend_full_q;
  logic             xfer;
  logic             swap;

  logic [3:0]       nibble;
  logic             dp_bit;
  logic [3:0]       lead_blank;
  logic [7:0]       seg_d;
  logic [3:0]       sel_d;

  function automatic logic [6:0] hex7seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------- scan FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      digit_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    digit_d  = digit_q;
    boundary = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SLOT_START;
          cnt_d   = '0;
          digit_d = '0;
        end
      end
      BLANK: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == BLANK_LAST) state_d = SHOW;
      end
      SHOW: begin
        if (cnt_q == SLOT_LAST) begin
          cnt_d    = '0;
          digit_d  = digit_q + 2'd1;
          boundary = (digit_q == 2'd3);
          state_d  = SLOT_START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Dropping en abandons the frame; the next enable restarts at digit 0.
    if (!en && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      digit_d = '0;
    end
  end

  assign frame_tick = boundary;

  // --------------------------------------------------------- double buffer
  assign upd_ready = ~pend_full_q;
  assign xfer      = upd_valid & upd_ready;
  // Pending is promoted at a frame boundary, or immediately while the scan is idle.
  assign swap      = pend_full_q & (boundary | (state_q == IDLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the buffers are reset, so a reset blanks the display and drops pending data.
      act_data_q  <= '0;
      act_dp_q    <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_full_q <= 1'b0;
    end else begin
      if (xfer) begin
        pend_data_q <= upd_data;
        pend_dp_q   <= upd_dp;
      end
      if (swap) begin
        act_data_q <= pend_data_q;
        act_dp_q   <= pend_dp_q;
      end
      if (xfer)      pend_full_q <= 1'b1;
      else if (swap) pend_full_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------- digit decode
  always_comb begin
    nibble = act_data_q[{digit_q, 2'b00} +: 4];
    dp_bit = act_dp_q[digit_q];
`ifdef DISPLAY_LZB_EN
    lead_blank[3] = (act_data_q[15:12] == 4'h0) && !act_dp_q[3];
    lead_blank[2] = lead_blank[3] && (act_data_q[11:8] == 4'h0) && !act_dp_q[2];
    lead_blank[1] = lead_blank[2] && (act_data_q[7:4] == 4'h0) && !act_dp_q[1];
    lead_blank[0] = 1'b0;
`else
    lead_blank = '0;
`endif
    seg_d = lead_blank[digit_q] ? 8'h00 : {dp_bit, hex7seg(nibble)};
    sel_d = 4'b0001 << digit_q;
  end

  // Pins are registered from the current state, so they trail the FSM by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segmentos <= '0;
      sel_seg   <= '0;
    end else if (state_q == SHOW) begin
      segmentos <= seg_d;
      sel_seg   <= sel_d;
    end else begin
      segmentos <= '0;
      sel_seg   <= '0;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: table of display values checked frame
// by frame through a scoreboard queue, plus hand-written multi-cycle sequences.
module tb_display_scan_ctrl;

  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * SLOT;

`ifdef DISPLAY_LZB_EN
  localparam logic [7:0] LZ = 8'h00;
`else
  localparam logic [7:0] LZ = 8'h3F;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_data = '0;
  logic [3:0]  upd_dp = '0;
  logic        upd_ready;
  logic [7:0]  segmentos;
  logic [3:0]  sel_seg;
  logic        frame_tick;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .SLOT_CYCLES (SLOT),
    .BLANK_CYCLES(BLANK),
    .CNT_W       (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .upd_valid (upd_valid),
    .upd_data  (upd_data),
    .upd_dp    (upd_dp),
    .upd_ready (upd_ready),
    .segmentos (segmentos),
    .sel_seg   (sel_seg),
    .frame_tick(frame_tick)
  );

  typedef struct packed {
    logic       tick;
    logic [3:0] sel;
    logic [7:0] seg;
  } obs_t;

  // seg[k] is the expected pattern of digit k.
  typedef struct packed {
    logic [15:0]     data;
    logic [3:0]      dp;
    logic [3:0][7:0] seg;
  } vec_t;

  vec_t vecs[8];
  obs_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Offset o = 0 is the second cycle after a frame_tick; o = 4*SLOT-2 carries the next tick.
  task automatic run_frame(input logic [3:0][7:0] segs, input int from_o, input int to_o);
    obs_t e;
    obs_t got;
    int   slot;
    int   pos;
    for (int o = from_o; o <= to_o; o++) begin
      slot   = o / SLOT;
      pos    = o % SLOT;
      e.tick = (o == FRAME - 2);
      if (pos < BLANK) begin
        e.sel = 4'b0000;
        e.seg = 8'h00;
      end else begin
        e.sel = 4'b0001 << slot;
        e.seg = segs[slot];
      end
      sb.push_back(e);
    end
    for (int o = from_o; o <= to_o; o++) begin
      @(negedge clk);
      e   = sb.pop_front();
      got = {frame_tick, sel_seg, segmentos};
      check($sformatf("frame offset %0d {tick,sel,seg}", o), 32'(got), 32'(e));
    end
  endtask

  task automatic send(input logic [15:0] d, input logic [3:0] p);
    int n;
    n         = 0;
    upd_valid = 1'b1;
    upd_data  = d;
    upd_dp    = p;
    while (!upd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send accepted within budget", upd_ready, 1);
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic sync_ready(input string name);
    int n;
    n = 0;
    while (!upd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, upd_ready, 1);
  endtask

  task automatic sync_tick(input string name);
    int n;
    n = 0;
    while (frame_tick !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, frame_tick, 1);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0][7:0] s1111;
    logic [3:0][7:0] s2222;
    int n;

    vecs[0] = '{data: 16'h1234, dp: 4'b0000, seg: {8'h06, 8'h5B, 8'h4F, 8'h66}};
    vecs[1] = '{data: 16'hABCD, dp: 4'b0000, seg: {8'h77, 8'h7C, 8'h39, 8'h5E}};
    vecs[2] = '{data: 16'h5678, dp: 4'b1010, seg: {8'hED, 8'h7D, 8'h87, 8'h7F}};
    vecs[3] = '{data: 16'h90EF, dp: 4'b0001, seg: {8'h6F, 8'h3F, 8'h79, 8'hF1}};
    vecs[4] = '{data: 16'h0042, dp: 4'b0000, seg: {LZ, LZ, 8'h66, 8'h5B}};
    vecs[5] = '{data: 16'h0042, dp: 4'b0100, seg: {LZ, 8'hBF, 8'h66, 8'h5B}};
    vecs[6] = '{data: 16'h0000, dp: 4'b0000, seg: {LZ, LZ, LZ, 8'h3F}};
    vecs[7] = '{data: 16'h0F00, dp: 4'b0000, seg: {LZ, 8'h71, 8'h3F, 8'h3F}};
    s1111   = {8'h06, 8'h06, 8'h06, 8'h06};
    s2222   = {8'h5B, 8'h5B, 8'h5B, 8'h5B};

    // Reset held with en high.
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset segmentos", segmentos, 0);
    check("reset sel_seg", sel_seg, 0);
    check("reset upd_ready", upd_ready, 1);
    check("reset frame_tick", frame_tick, 0);
    rst_n = 1'b1;
    for (int i = 1; i <= BLANK + 2; i++) begin
      @(negedge clk);
      if (i < BLANK + 2) check($sformatf("startup dark cycle %0d", i), {sel_seg, segmentos}, 0);
      else check("startup first digit 0", {sel_seg, segmentos}, {4'b0001, 8'h3F});
    end

    // Table-driven display values, each checked over one full frame.
    for (int v = 0; v < 8; v++) begin
      send(vecs[v].data, vecs[v].dp);
      check($sformatf("vec%0d ready low after transfer", v), upd_ready, 0);
      sync_ready($sformatf("vec%0d promoted at boundary", v));
      run_frame(vecs[v].seg, 0, FRAME - 1);
    end

    // Tear-free update offered during digit 1 of a 1234 frame.
    send(16'h1234, 4'b0000);
    sync_ready("tear: 1234 promoted");
    run_frame(vecs[0].seg, 0, 10);
    upd_valid = 1'b1;
    upd_data  = 16'hABCD;
    upd_dp    = 4'b0000;
    run_frame(vecs[0].seg, 11, 11);
    upd_valid = 1'b0;
    check("tear: ready low after transfer", upd_ready, 0);
    run_frame(vecs[0].seg, 12, FRAME - 1);
    check("tear: ready high after boundary", upd_ready, 1);
    run_frame(vecs[1].seg, 0, FRAME - 1);

    // Back-pressure: 1111 accepted, 2222 held until the boundary frees pending.
    upd_valid = 1'b1;
    upd_data  = 16'h1111;
    run_frame(vecs[1].seg, 0, 0);
    upd_data = 16'h2222;
    check("bp: ready low holding 1111", upd_ready, 0);
    run_frame(vecs[1].seg, 1, FRAME - 1);
    check("bp: ready high after boundary", upd_ready, 1);
    run_frame(s1111, 0, 0);
    upd_valid = 1'b0;
    check("bp: 2222 taken", upd_ready, 0);
    run_frame(s1111, 1, FRAME - 1);
    run_frame(s2222, 0, FRAME - 1);

    // Disable during digit 2 SHOW.
    run_frame(s2222, 0, 19);
    en = 1'b0;
    @(negedge clk);
    check("disable: output lags one cycle", {sel_seg, segmentos}, {4'b0100, 8'h5B});
    @(negedge clk);
    check("disable: dark after two cycles", {frame_tick, sel_seg, segmentos}, 0);

    // Idle promotes pending without waiting for a frame.
    send(16'h1234, 4'b0000);
    check("idle: pending full after transfer", upd_ready, 0);
    @(negedge clk);
    check("idle: pending promoted next cycle", upd_ready, 1);
    check("idle: still dark", {frame_tick, sel_seg, segmentos}, 0);

    // Re-enable restarts at digit 0 after the blank phase.
    en = 1'b1;
    n  = 0;
    while (sel_seg == 4'b0000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("re-enable: cycles to first select", n, BLANK + 2);
    check("re-enable: digit 0 of 1234", {sel_seg, segmentos}, {4'b0001, 8'h66});

    // Asynchronous reset mid-frame discards pending data.
    send(16'h7777, 4'b1111);
    check("rst: pending holds 7777", upd_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst: async outputs cleared", {frame_tick, sel_seg, segmentos}, 0);
    check("rst: pending emptied", upd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    sync_tick("rst: frame tick after restart");
    run_frame(vecs[6].seg, 0, FRAME - 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1);
  end

endmodule
